acc_scheduler: RTL and testbench

ACC_SCHEDULER -- requirements
Module: acc_scheduler

---
 rtl/acc_scheduler_pkg.sv | 18 +
 rtl/acc_scheduler_rr_arbiter.sv | 29 ++
 rtl/acc_scheduler.sv | 104 ++++++++++
 tb/tb_acc_scheduler.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_scheduler_pkg.sv
// Shared types and constants for the shared-accumulator scheduler.
package acc_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    EXEC = 2'd2
  } state_t;

  localparam logic OP_ADD   = 1'b0;
  localparam logic OP_CLEAR = 1'b1;

  // Position 'off' steps after 'base' on a ring of n requesters.
  function automatic int unsigned ring_index(int unsigned base, int unsigned off, int unsigned n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/acc_scheduler_rr_arbiter.sv
// Round-robin requester selection: first active request after last_grant, wrapping.
module rr_arbiter
  import acc_scheduler_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last_grant,
  output logic [IDW-1:0]  grant,
  output logic            any_req
);

  always_comb begin
    logic [IDW-1:0] idx;
    grant   = last_grant;
    any_req = 1'b0;
    idx     = '0;
    // Scan farthest-first so the nearest requester after last_grant is the final winner.
    for (int unsigned off = NREQ; off >= 1; off--) begin
      idx = IDW'(ring_index(32'(last_grant), off, NREQ));
      if (req[idx]) begin
        grant   = idx;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/acc_scheduler.sv
// Accumulator shared by NREQ requesters; one add/clear applied per three-cycle
// IDLE -> XFER -> EXEC transaction with a round-robin grant.
module acc_scheduler #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned ADD_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ-1:0]           req_op,
  input  logic [NREQ*ADD_WIDTH-1:0] req_data,
  output logic [NREQ-1:0]           req_ready,
  output logic [ACC_WIDTH-1:0]      acc_data,
  output logic                      acc_msb,
  output logic                      acc_ovf,
  output logic                      done,
  output logic [$clog2(NREQ)-1:0]   done_id,
  output logic                      busy
);
  import acc_scheduler_pkg::*;

  localparam int unsigned IDW = $clog2(NREQ);

  state_t                 state;
  logic [IDW-1:0]         grant;
  logic [IDW-1:0]         last_grant;
  logic [IDW-1:0]         arb_grant;
  logic                   arb_any;
  logic                   op_q;
  logic [ADD_WIDTH-1:0]   data_q;
  logic [ADD_WIDTH-1:0]   data_arr [NREQ];
  logic [ACC_WIDTH:0]     sum;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .any_req    (arb_any)
  );

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      data_arr[i] = req_data[i*ADD_WIDTH +: ADD_WIDTH];
    end
  end

  // Extra top bit carries the wrap-around out of the accumulator.
  assign sum     = {1'b0, acc_data} + {{(ACC_WIDTH+1-ADD_WIDTH){1'b0}}, data_q};
  assign acc_msb = acc_data[ACC_WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= IDW'(NREQ-1);
      op_q       <= OP_ADD;
      data_q     <= '0;
      acc_data   <= '0;
      acc_ovf    <= 1'b0;
      done       <= 1'b0;
      done_id    <= '0;
      req_ready  <= '0;
      busy       <= 1'b0;
    end else begin
      done      <= 1'b0;
      req_ready <= '0;
      case (state)
        IDLE: begin
          if (arb_any) begin
            grant     <= arb_grant;
            req_ready <= NREQ'(1) << arb_grant;
            busy      <= 1'b1;
            state     <= XFER;
          end
        end
        XFER: begin
          op_q   <= req_op[grant];
          data_q <= data_arr[grant];
          state  <= EXEC;
        end
        EXEC: begin
          if (op_q == OP_CLEAR) begin
            acc_data <= '0;
            acc_ovf  <= 1'b0;
          end else begin
            acc_data <= sum[ACC_WIDTH-1:0];
            acc_ovf  <= acc_ovf | sum[ACC_WIDTH];
          end
          last_grant <= grant;
          done       <= 1'b1;
          done_id    <= grant;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_scheduler.sv
// Scoreboard bench for acc_scheduler: a cycle-level transaction model predicts
// grants, acceptance strobes and accumulator results; a monitor checks them.
module tb_acc_scheduler;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned ACC_W = 32;
  localparam int unsigned ADD_W = 24;
  localparam int unsigned IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_op;
  logic [NREQ*ADD_W-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic [ACC_W-1:0]      acc_data;
  logic                  acc_msb;
  logic                  acc_ovf;
  logic                  done;
  logic [IDW-1:0]        done_id;
  logic                  busy;

  acc_scheduler #(
    .NREQ      (NREQ),
    .ACC_WIDTH (ACC_W),
    .ADD_WIDTH (ADD_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_data  (req_data),
    .req_ready (req_ready),
    .acc_data  (acc_data),
    .acc_msb   (acc_msb),
    .acc_ovf   (acc_ovf),
    .done      (done),
    .done_id   (done_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void check(bit ok, string name, string got, string exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %s, expected %s (cycle %0d)", name, got, exp, cyc);
  endfunction

  typedef struct {
    int              cyc;
    logic [NREQ-1:0] ready;
  } rdy_t;

  typedef struct {
    int               cyc;
    int               id;
    logic [ACC_W-1:0] acc;
    logic             ovf;
  } dn_t;

  rdy_t rq[$];
  dn_t  dq[$];

  // Requester side and reference model
  logic [NREQ-1:0]  pend;
  bit               p_op     [NREQ];
  logic [ADD_W-1:0] p_data   [NREQ];
  int               rel_edge [NREQ];
  int               next_arb = 0;
  int               m_last   = NREQ - 1;
  logic [ACC_W-1:0] m_acc    = '0;
  logic             m_ovf    = 1'b0;
  int               n_arb    = 0;

  task automatic arm(int i, bit op, logic [ADD_W-1:0] d);
    if (!pend[i]) begin
      pend[i]   = 1'b1;
      p_op[i]   = op;
      p_data[i] = d;
    end
  endtask

  // Called just after a falling edge: decide what the next rising edge sees.
  task automatic step();
    int k;
    int g;
    longint unsigned s;
    k = cyc;
    if (!rst && k + 1 >= next_arb && pend != '0) begin
      g = m_last;
      do g = (g + 1) % NREQ; while (!pend[g]);
      rq.push_back('{k + 1, NREQ'(1) << g});
      if (p_op[g]) begin
        m_acc = '0;
        m_ovf = 1'b0;
      end else begin
        s = longint'(m_acc) + longint'(p_data[g]);
        if (s >= 64'h1_0000_0000) begin
          m_ovf = 1'b1;
          s     = s - 64'h1_0000_0000;
        end
        m_acc = ACC_W'(s);
      end
      dq.push_back('{k + 3, g, m_acc, m_ovf});
      m_last      = g;
      next_arb    = k + 4;
      rel_edge[g] = k + 2;
      n_arb++;
    end
    req_valid = pend;
    for (int i = 0; i < NREQ; i++) begin
      req_op[i]                  = p_op[i];
      req_data[i*ADD_W +: ADD_W] = p_data[i];
    end
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      if (rel_edge[i] == cyc) begin
        pend[i]     = 1'b0;
        rel_edge[i] = -1;
      end
    end
  endtask

  task automatic do_reset(int n);
    rst       = 1'b1;
    pend      = '0;
    req_valid = '0;
    for (int i = 0; i < NREQ; i++) rel_edge[i] = -1;
    rq.delete();
    dq.delete();
    m_acc  = '0;
    m_ovf  = 1'b0;
    m_last = NREQ - 1;
    repeat (n) @(negedge clk);
    rst      = 1'b0;
    next_arb = cyc + 1;
  endtask

  task automatic run_op(int i, bit op, logic [ADD_W-1:0] d);
    int start;
    start = n_arb;
    arm(i, op, d);
    for (int t = 0; t < 12 && n_arb == start; t++) step();
    repeat (3) step();
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && pend != '0; t++) step();
    repeat (4) step();
  endtask

  task automatic check_acc(string name, logic [ACC_W-1:0] exp_acc, logic exp_ovf);
    check(acc_data === exp_acc && acc_ovf === exp_ovf && acc_msb === exp_acc[ACC_W-1], name,
          $sformatf("acc=%h ovf=%b msb=%b", acc_data, acc_ovf, acc_msb),
          $sformatf("acc=%h ovf=%b msb=%b", exp_acc, exp_ovf, exp_acc[ACC_W-1]));
  endtask

  // Monitor
  always @(negedge clk) begin
    rdy_t r;
    dn_t  d;
    if (req_ready !== '0) begin
      if (rq.size() == 0) begin
        check(1'b0, "ready_unexpected", $sformatf("ready=%b", req_ready), "ready=0000");
      end else begin
        r = rq.pop_front();
        check(req_ready === r.ready && cyc == r.cyc && busy === 1'b1, "ready",
              $sformatf("ready=%b cyc=%0d busy=%b", req_ready, cyc, busy),
              $sformatf("ready=%b cyc=%0d busy=1", r.ready, r.cyc));
      end
    end
    if (done !== 1'b0) begin
      if (dq.size() == 0) begin
        check(1'b0, "done_unexpected", $sformatf("done=%b id=%0d", done, done_id), "done=0");
      end else begin
        d = dq.pop_front();
        check(int'(done_id) == d.id && cyc == d.cyc && acc_data === d.acc && acc_ovf === d.ovf
              && acc_msb === d.acc[ACC_W-1] && busy === 1'b0, "done",
              $sformatf("id=%0d cyc=%0d acc=%h ovf=%b msb=%b busy=%b",
                        done_id, cyc, acc_data, acc_ovf, acc_msb, busy),
              $sformatf("id=%0d cyc=%0d acc=%h ovf=%b msb=%b busy=0",
                        d.id, d.cyc, d.acc, d.ovf, d.acc[ACC_W-1]));
      end
    end
    if (rq.size() != 0 && rq[0].cyc < cyc) begin
      r = rq.pop_front();
      check(1'b0, "ready_missing", "no strobe", $sformatf("ready=%b at cyc %0d", r.ready, r.cyc));
    end
    if (dq.size() != 0 && dq[0].cyc < cyc) begin
      d = dq.pop_front();
      check(1'b0, "done_missing", "no pulse", $sformatf("id=%0d at cyc %0d", d.id, d.cyc));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    pend      = '0;
    req_valid = '0;
    req_op    = '0;
    req_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      p_op[i]     = 1'b0;
      p_data[i]   = '0;
      rel_edge[i] = -1;
    end

    do_reset(3);
    check(acc_data === '0 && acc_ovf === 1'b0 && acc_msb === 1'b0, "reset_acc",
          $sformatf("acc=%h ovf=%b msb=%b", acc_data, acc_ovf, acc_msb), "acc=0 ovf=0 msb=0");
    check(done === 1'b0 && done_id === '0, "reset_done",
          $sformatf("done=%b id=%0d", done, done_id), "done=0 id=0");
    check(req_ready === '0 && busy === 1'b0, "reset_ready_busy",
          $sformatf("ready=%b busy=%b", req_ready, busy), "ready=0000 busy=0");

    // Single add from requester 2
    run_op(2, 1'b0, 24'h05);
    check_acc("single_add", 32'h5, 1'b0);

    // Round robin with all four requesters holding valid
    do_reset(2);
    start = n_arb;
    for (int i = 0; i < NREQ; i++) arm(i, 1'b0, 24'h1);
    for (int t = 0; t < 40 && n_arb - start < 5; t++) begin
      step();
      if (n_arb - start < 5) for (int i = 0; i < NREQ; i++) arm(i, 1'b0, 24'h1);
    end
    repeat (2) step();
    check_acc("round_robin_five", 32'h5, 1'b0);
    drain();

    // Late arrival while requester 0 is in transfer
    do_reset(2);
    start = n_arb;
    arm(0, 1'b0, 24'h7);
    for (int t = 0; t < 12 && n_arb == start; t++) step();
    check(req_ready === 4'b0001, "late_first_grant", $sformatf("ready=%b", req_ready), "ready=0001");
    arm(3, 1'b0, 24'h9);
    for (int t = 0; t < 12 && n_arb - start < 2; t++) step();
    check(req_ready === 4'b1000, "late_second_grant", $sformatf("ready=%b", req_ready), "ready=1000");
    repeat (3) step();
    check_acc("late_sum", 32'h10, 1'b0);

    // Wrap-around
    run_op(1, 1'b1, 24'h0);
    repeat (256) run_op(0, 1'b0, 24'hFFFFFF);
    run_op(0, 1'b0, 24'hFE);
    check_acc("preload", 32'hFFFF_FFFE, 1'b0);
    run_op(2, 1'b0, 24'h03);
    check_acc("wrap", 32'h0000_0001, 1'b1);
    run_op(3, 1'b0, 24'h00);
    check_acc("add_zero_sticky", 32'h0000_0001, 1'b1);

    // Clear from requester 1
    run_op(1, 1'b1, 24'hABCDEF);
    check_acc("clear", 32'h0, 1'b0);

    // Reset during EXEC discards the add
    run_op(0, 1'b0, 24'h20);
    check_acc("pre_reset_value", 32'h20, 1'b0);
    start = n_arb;
    arm(1, 1'b0, 24'h10);
    for (int t = 0; t < 12 && n_arb == start; t++) step();
    step();
    do_reset(1);
    check(acc_data === '0 && done === 1'b0, "reset_mid_op",
          $sformatf("acc=%h done=%b", acc_data, done), "acc=0 done=0");
    start = n_arb;
    arm(1, 1'b0, 24'h1);
    arm(0, 1'b0, 24'h2);
    for (int t = 0; t < 12 && n_arb == start; t++) step();
    check(req_ready === 4'b0001, "post_reset_grant", $sformatf("ready=%b", req_ready), "ready=0001");
    drain();
    check_acc("post_reset_sum", 32'h3, 1'b0);

    // Randomized traffic
    for (int t = 0; t < 900; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          if ($urandom_range(0, 3) == 0)
            arm(i, ($urandom_range(0, 15) == 0), ADD_W'(24'hFFFFFF - $urandom_range(0, 255)));
          else
            arm(i, ($urandom_range(0, 15) == 0), ADD_W'($urandom));
        end
      end
      step();
    end
    drain();
    check(rq.size() == 0 && dq.size() == 0, "queues_drained",
          $sformatf("ready_q=%0d done_q=%0d", rq.size(), dq.size()), "both empty");
    check_acc("final_acc", m_acc, m_ovf);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
